serial_adder: RTL and testbench

- Multi-cycle, parametrised successor to the single-bit full adder.
- Adds, or subtracts, two WIDTH-bit operands CHUNK bits per clock, using one CHUNK-bit adder slice and a carry flip-flop.
- Start/busy/done handshake; registered result held until the next operation completes.
- Used in area-constrained datapaths where a full-width single-cycle adder is not wanted.

---
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract of two WIDTH-bit operands, CHUNK
// bits per clock through a single CHUNK-bit adder slice and a carry flop.
// Start/busy/done handshake; the result registers update only when an
// operation completes and hold until the next one completes.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] res_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;

  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] res_next;
  logic             last_chunk;
  logic             accept;

  // One CHUNK-bit slice of the addition, with its carry-out in the top bit.
  always_comb begin
    slice = {1'b0, op_a_reg[CHUNK-1:0]} + {1'b0, op_b_reg[CHUNK-1:0]}
          + {{CHUNK{1'b0}}, carry_reg};
  end

  // New chunk enters the result register from the MSB end; when a single
  // chunk covers the whole word there is nothing to shift down.
  generate
    if (CHUNK < WIDTH) begin : g_shift
      assign res_next = {slice[CHUNK-1:0], res_reg[WIDTH-1:CHUNK]};
    end else begin : g_whole
      assign res_next = slice[CHUNK-1:0];
    end
  endgenerate

  assign last_chunk = (count_reg == CW'(N - 1));
  // A new operation can start from IDLE or straight out of the DONE cycle.
  assign accept     = start && ((state_reg == IDLE) || (state_reg == DONE));

  // Control FSM, operand shifting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      carry_reg    <= 1'b0;
      count_reg    <= '0;
      res_reg      <= '0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        BUSY: begin
          carry_reg <= slice[CHUNK];
          op_a_reg  <= op_a_reg >> CHUNK;
          op_b_reg  <= op_b_reg >> CHUNK;
          res_reg   <= res_next;
          count_reg <= count_reg + CW'(1);
          if (last_chunk) begin
            state_reg    <= DONE;
            sum_reg      <= res_next;
            cout_reg     <= slice[CHUNK];
            // B msb is the post-inversion one, so this covers subtraction too.
            overflow_reg <= (a_msb_reg == b_msb_reg) &&
                            (res_next[WIDTH-1] != a_msb_reg);
          end
        end
        default: begin
          if (accept) begin
            state_reg <= BUSY;
            op_a_reg  <= a;
            op_b_reg  <= sub ? ~b : b;
            carry_reg <= sub ? 1'b1 : cin;
            count_reg <= '0;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = (state_reg == BUSY);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: two instances (CHUNK=1 and CHUNK=4, WIDTH=8)
// sharing operand inputs; a select bit routes start and observed outputs.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       sel = 1'b0;

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  logic       start1, start4;
  logic       busy_m, done_m, cout_m, ovf_m;
  logic [7:0] sum_m;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start4 = start & sel;
  assign busy_m = sel ? busy4 : busy1;
  assign done_m = sel ? done4 : done1;
  assign sum_m  = sel ? sum4  : sum1;
  assign cout_m = sel ? cout4 : cout1;
  assign ovf_m  = sel ? ovf4  : ovf1;

  serial_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  // Reference: plain unsigned/signed arithmetic on the whole words.
  function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                input logic c, input logic s,
                                output logic [7:0] rs, output logic rc,
                                output logic ro);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int u;
    int r;
    if (s) begin
      u  = ux - uy;
      rc = (ux >= uy);
      r  = sx - sy;
    end else begin
      u  = ux + uy + int'(c);
      rc = (u > 255);
      r  = sx + sy + int'(c);
    end
    rs = u[7:0];
    ro = (r > 127) || (r < -128);
  endfunction

  // Called at a negedge: present operands with start for one edge.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic ts);
    a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until done; scrambles inputs meanwhile. Returns at
  // the negedge where done is high (or after a bounded wait).
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_m) begin
        seen = 1'b1;
      end else begin
        if (busy_m) nbusy++;
        a = 8'($urandom); b = 8'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        @(negedge clk);
      end
    end
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts,
                       output int nbusy, output bit seen);
    @(negedge clk);
    launch(ta, tb, tc, ts);
    wait_done(nbusy, seen);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total_cnt++;
      if ({busy_m, done_m, sum_m, cout_m, ovf_m} !== 12'h000)
        $display("FAIL reset_sel%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                 s, busy_m, done_m, sum_m, cout_m, ovf_m);
      else pass_cnt++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      total_cnt++;
      if ({busy_m, done_m, sum_m, cout_m, ovf_m} !== 12'h000)
        $display("FAIL idle_after_reset_sel%0d: busy=%b done=%b sum=%h, expected idle zeros",
                 s, busy_m, done_m, sum_m);
      else pass_cnt++;
    end
    sel = 1'b0;
  endtask

  // Directed operation with full result and latency checks.
  task automatic test_directed(input string name, input logic [7:0] ta,
                               input logic [7:0] tb, input logic tc,
                               input logic ts, input logic [7:0] esum,
                               input logic ecout, input logic eovf);
    int nb;
    bit seen;
    int en;
    en = sel ? 2 : 8;
    do_op(ta, tb, tc, ts, nb, seen);
    total_cnt++;
    if (!seen) $display("FAIL %s_done: done never seen within bound", name);
    else pass_cnt++;
    total_cnt++;
    if (nb !== en) $display("FAIL %s_busy_cycles: got %0d expected %0d", name, nb, en);
    else pass_cnt++;
    total_cnt++;
    if ({sum_m, cout_m, ovf_m} !== {esum, ecout, eovf})
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               name, sum_m, cout_m, ovf_m, esum, ecout, eovf);
    else pass_cnt++;
    total_cnt++;
    if (busy_m !== 1'b0) $display("FAIL %s_busy_in_done: busy=%b expected 0", name, busy_m);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done_m !== 1'b0 || sum_m !== esum)
      $display("FAIL %s_done_pulse: done=%b sum=%h expected done=0 sum=%h",
               name, done_m, sum_m, esum);
    else pass_cnt++;
  endtask

  task automatic test_random(input int count);
    logic [7:0] ta, tb, es;
    logic tc, ts, ec, eo;
    int nb;
    bit seen;
    for (int i = 0; i < count; i++) begin
      ta = 8'($urandom); tb = 8'($urandom);
      tc = 1'($urandom); ts = 1'($urandom);
      model(ta, tb, tc, ts, es, ec, eo);
      do_op(ta, tb, tc, ts, nb, seen);
      total_cnt++;
      if (!seen || nb !== (sel ? 2 : 8) || {sum_m, cout_m, ovf_m} !== {es, ec, eo})
        $display("FAIL random_sel%0d_%0d: a=%h b=%h cin=%b sub=%b seen=%b busy=%0d sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 sel, i, ta, tb, tc, ts, seen, nb, sum_m, cout_m, ovf_m, es, ec, eo);
      else pass_cnt++;
    end
  endtask

  // start pulsed mid-operation with other operands must be ignored.
  task automatic test_busy_ignore;
    logic [7:0] es, prev;
    logic ec, eo;
    int nb;
    bit seen;
    model(8'h21, 8'h13, 1'b0, 1'b0, es, ec, eo);
    prev = sum_m;
    @(negedge clk);
    launch(8'h21, 8'h13, 1'b0, 1'b0);
    @(negedge clk);
    launch(8'hF0, 8'hF0, 1'b1, 1'b0);
    total_cnt++;
    if (sum_m !== prev) $display("FAIL ignore_hold: sum=%h expected held %h", sum_m, prev);
    else pass_cnt++;
    wait_done(nb, seen);
    total_cnt++;
    if (!seen || nb !== 6 || {sum_m, cout_m, ovf_m} !== {es, ec, eo})
      $display("FAIL ignore_result: seen=%b busy=%0d sum=%h cout=%b ovf=%b expected busy=6 sum=%h cout=%b ovf=%b",
               seen, nb, sum_m, cout_m, ovf_m, es, ec, eo);
    else pass_cnt++;
  endtask

  // start during the DONE cycle: no idle gap, old sum held until next done.
  task automatic test_back_to_back;
    logic [7:0] es1, es2;
    logic ec1, eo1, ec2, eo2;
    int nb;
    bit seen;
    model(8'h44, 8'h55, 1'b1, 1'b0, es1, ec1, eo1);
    model(8'h03, 8'h09, 1'b0, 1'b1, es2, ec2, eo2);
    do_op(8'h44, 8'h55, 1'b1, 1'b0, nb, seen);
    total_cnt++;
    if (!seen || sum_m !== es1) $display("FAIL b2b_first: seen=%b sum=%h expected %h", seen, sum_m, es1);
    else pass_cnt++;
    launch(8'h03, 8'h09, 1'b0, 1'b1);
    total_cnt++;
    if (busy_m !== 1'b1 || done_m !== 1'b0 || sum_m !== es1)
      $display("FAIL b2b_no_gap: busy=%b done=%b sum=%h expected busy=1 done=0 sum=%h",
               busy_m, done_m, sum_m, es1);
    else pass_cnt++;
    wait_done(nb, seen);
    total_cnt++;
    if (!seen || nb !== (sel ? 2 : 8) || {sum_m, cout_m, ovf_m} !== {es2, ec2, eo2})
      $display("FAIL b2b_second: seen=%b busy=%0d sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               seen, nb, sum_m, cout_m, ovf_m, es2, ec2, eo2);
    else pass_cnt++;
  endtask

  // Reset asserted in the second busy cycle aborts without a done pulse.
  task automatic test_reset_mid;
    int nb;
    bit seen;
    bit bad;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, nb, seen);
    @(negedge clk);
    launch(8'h55, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (busy_m !== 1'b1) $display("FAIL midrst_pre_busy: busy=%b expected 1", busy_m);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy_m, done_m, sum_m, cout_m, ovf_m} !== 12'h000)
      $display("FAIL midrst_clear: busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy_m, done_m, sum_m, cout_m, ovf_m);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_m !== 1'b0 || busy_m !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL midrst_no_done: done/busy seen after abort, expected idle");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    sel = 1'b0;
    test_directed("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    test_directed("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    test_directed("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    test_directed("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    test_busy_ignore();
    test_back_to_back();
    test_random(20);
    sel = 1'b1;
    test_reset_mid();
    test_directed("c4_add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    test_back_to_back();
    test_random(20);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
